reg_file_sched: RTL and testbench

REG_FILE_SCHED -- requirements
Module: reg_file_sched

---
 rtl/reg_file_sched_pkg.sv | 16 +
 rtl/reg_file_sched_if.sv | 10 +
 rtl/rr_arb2.sv | 34 +++
 rtl/reg_file_sched.sv | 126 ++++++++++++
 tb/tb_reg_file_sched.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_sched_pkg.sv
// Shared types and constants for the register-file scheduler.
// Used by reg_file_sched and rr_arb2.
package reg_file_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SW_RD_A = 3'd1,
    SW_RD_B = 3'd2,
    SW_WR_A = 3'd3,
    SW_WR_B = 3'd4
  } state_e;

  // Number of cycles swap_busy stays high for one swap (done pulse excluded).
  localparam int SWAP_CYCLES = 4;

endpackage

// File: rtl/reg_file_sched_if.sv
// Arbitration bus between the scheduler FSM (master) and the client arbiter (slave).
// Handshake: gnt is combinational from req and grant_en; a set gnt bit means that client's access happens this cycle.
interface reg_file_sched_if;
  logic [1:0] req;
  logic       grant_en;
  logic [1:0] gnt;

  modport master (output req, output grant_en, input gnt);
  modport slave  (input req, input grant_en, output gnt);
endinterface

// File: rtl/rr_arb2.sv
// Two-client arbiter producing a one-hot grant.
// REG_FILE_SCHED_RR_EN selects round-robin; otherwise c0 has fixed priority.
module rr_arb2 (
`ifdef REG_FILE_SCHED_RR_EN
  input logic clk,
  input logic reset_n,
`endif
  reg_file_sched_if.slave arb
);

`ifdef REG_FILE_SCHED_RR_EN
  // prio_q = 1 means c1 wins a tie; it points away from the last winner.
  logic prio_q;

  always_comb begin
    arb.gnt = 2'b00;
    if (arb.grant_en) begin
      if (arb.req == 2'b11) arb.gnt = prio_q ? 2'b10 : 2'b01;
      else                  arb.gnt = arb.req;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               prio_q <= 1'b0;
    else if (arb.gnt != 2'b00)  prio_q <= arb.gnt[0];
  end
`else
  always_comb begin
    arb.gnt = 2'b00;
    if (arb.grant_en) arb.gnt = arb.req[0] ? 2'b01 : {arb.req[1], 1'b0};
  end
`endif

endmodule

// File: rtl/reg_file_sched.sv
// Register-file access scheduler: two arbitrated clients plus an atomic swap engine.
// Build option: define REG_FILE_SCHED_RR_EN for round-robin client arbitration.
module reg_file_sched
  import reg_file_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  c0_valid,
  input  logic                  c0_we,
  input  logic [ADDR_WIDTH-1:0] c0_addr,
  input  logic [DATA_WIDTH-1:0] c0_wdata,
  output logic                  c0_ready,
  output logic                  c0_rvalid,
  input  logic                  c1_valid,
  input  logic                  c1_we,
  input  logic [ADDR_WIDTH-1:0] c1_addr,
  input  logic [DATA_WIDTH-1:0] c1_wdata,
  output logic                  c1_ready,
  output logic                  c1_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  swap_start,
  input  logic [ADDR_WIDTH-1:0] swap_addr_a,
  input  logic [ADDR_WIDTH-1:0] swap_addr_b,
  output logic                  swap_busy,
  output logic                  swap_done,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_addr_w,
  output logic [ADDR_WIDTH-1:0] rf_addr_r,
  output logic [DATA_WIDTH-1:0] rf_data_w,
  input  logic [DATA_WIDTH-1:0] rf_data_r,
  output state_e                state_dbg_o
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_b_q;
  logic [DATA_WIDTH-1:0] tmp_a_q, tmp_b_q, rdata_q;
  logic                  c0_rvalid_q, c1_rvalid_q, swap_done_q;
  logic                  rd0, rd1;

  reg_file_sched_if arb_bus ();

  // The done cycle still belongs to the swap, so clients wait one more cycle.
  assign arb_bus.req      = {c1_valid, c0_valid};
  assign arb_bus.grant_en = reset_n & (state_q == IDLE) & ~swap_start & ~swap_done_q;

  rr_arb2 u_arb (
`ifdef REG_FILE_SCHED_RR_EN
    .clk     (clk),
    .reset_n (reset_n),
`endif
    .arb     (arb_bus.slave)
  );

  assign c0_ready    = arb_bus.gnt[0];
  assign c1_ready    = arb_bus.gnt[1];
  assign rd0         = arb_bus.gnt[0] & ~c0_we;
  assign rd1         = arb_bus.gnt[1] & ~c1_we;
  assign c0_rvalid   = c0_rvalid_q;
  assign c1_rvalid   = c1_rvalid_q;
  assign rdata       = rdata_q;
  assign swap_done   = swap_done_q;
  assign swap_busy   = (state_q != IDLE);
  assign state_dbg_o = state_q;

  always_comb begin
    rf_we     = 1'b0;
    rf_addr_w = '0;
    rf_addr_r = '0;
    rf_data_w = '0;
    case (state_q)
      IDLE: begin
        if (arb_bus.gnt[0]) begin
          rf_we = c0_we; rf_addr_w = c0_addr; rf_addr_r = c0_addr; rf_data_w = c0_wdata;
        end else if (arb_bus.gnt[1]) begin
          rf_we = c1_we; rf_addr_w = c1_addr; rf_addr_r = c1_addr; rf_data_w = c1_wdata;
        end
      end
      SW_RD_A: rf_addr_r = addr_a_q;
      SW_RD_B: rf_addr_r = addr_b_q;
      SW_WR_A: begin rf_we = 1'b1; rf_addr_w = addr_a_q; rf_data_w = tmp_b_q; end
      SW_WR_B: begin rf_we = 1'b1; rf_addr_w = addr_b_q; rf_data_w = tmp_a_q; end
      default: ;
    endcase
    // Reset silences the bus at once, so a swap cut in SW_WR_B never writes B.
    if (!reset_n) begin
      rf_we = 1'b0; rf_addr_w = '0; rf_addr_r = '0; rf_data_w = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      tmp_a_q     <= '0;
      tmp_b_q     <= '0;
      rdata_q     <= '0;
      c0_rvalid_q <= 1'b0;
      c1_rvalid_q <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      c0_rvalid_q <= rd0;
      c1_rvalid_q <= rd1;
      if (rd0 | rd1) rdata_q <= rf_data_r;
      swap_done_q <= (state_q == SW_WR_B);
      case (state_q)
        IDLE: begin
          if (swap_start) begin
            addr_a_q <= swap_addr_a;
            addr_b_q <= swap_addr_b;
            state_q  <= SW_RD_A;
          end
        end
        SW_RD_A: begin tmp_a_q <= rf_data_r; state_q <= SW_RD_B; end
        SW_RD_B: begin tmp_b_q <= rf_data_r; state_q <= SW_WR_A; end
        SW_WR_A: state_q <= SW_WR_B;
        SW_WR_B: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_sched.sv
// Directed self-checking bench for reg_file_sched with a behavioural register file.
module tb_reg_file_sched;
  import reg_file_sched_pkg::*;

  localparam int AW = 7;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          c0_valid, c0_we, c0_ready, c0_rvalid;
  logic [AW-1:0] c0_addr;
  logic [DW-1:0] c0_wdata;
  logic          c1_valid, c1_we, c1_ready, c1_rvalid;
  logic [AW-1:0] c1_addr;
  logic [DW-1:0] c1_wdata;
  logic [DW-1:0] rdata;
  logic          swap_start, swap_busy, swap_done;
  logic [AW-1:0] swap_addr_a, swap_addr_b;
  logic          rf_we;
  logic [AW-1:0] rf_addr_w, rf_addr_r;
  logic [DW-1:0] rf_data_w, rf_data_r;
  state_e        state_dbg;

  logic [DW-1:0] mem [128] = '{default: '0};
  logic [1:0]    exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int busy_n, done_n, done_at, grant_at;

  always #5 clk = ~clk;

  always @(posedge clk) if (rf_we) mem[rf_addr_w] <= rf_data_w;
  assign rf_data_r = mem[rf_addr_r];

  reg_file_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .c0_valid(c0_valid), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_ready(c0_ready), .c0_rvalid(c0_rvalid),
    .c1_valid(c1_valid), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_ready(c1_ready), .c1_rvalid(c1_rvalid),
    .rdata(rdata),
    .swap_start(swap_start), .swap_addr_a(swap_addr_a), .swap_addr_b(swap_addr_b),
    .swap_busy(swap_busy), .swap_done(swap_done),
    .rf_we(rf_we), .rf_addr_w(rf_addr_w), .rf_addr_r(rf_addr_r),
    .rf_data_w(rf_data_w), .rf_data_r(rf_data_r),
    .state_dbg_o(state_dbg)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  task automatic client_wr(input bit c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    if (!c) begin c0_valid = 1'b1; c0_we = 1'b1; c0_addr = a; c0_wdata = d; end
    else    begin c1_valid = 1'b1; c1_we = 1'b1; c1_addr = a; c1_wdata = d; end
    #1;
    check_eq("wr_ready", 32'(c ? c1_ready : c0_ready), 1);
    @(negedge clk);
    c0_valid = 1'b0; c1_valid = 1'b0; c0_we = 1'b0; c1_we = 1'b0;
  endtask

  task automatic run_swap(input logic [AW-1:0] a, input logic [AW-1:0] b, input int repulse_at,
                          output int nb, output int nd);
    @(negedge clk);
    swap_start = 1'b1; swap_addr_a = a; swap_addr_b = b;
    #1;
    check_eq("swap_start_not_busy", 32'(swap_busy), 0);
    nb = 0; nd = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      swap_start = (i == repulse_at);
      #1;
      if (swap_busy) nb++;
      if (swap_done) nd++;
    end
    swap_start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    c0_valid = 1'b1; c0_we = 1'b1; c0_addr = '0; c0_wdata = '0;
    c1_valid = 1'b0; c1_we = 1'b0; c1_addr = '0; c1_wdata = '0;
    swap_start = 1'b0; swap_addr_a = '0; swap_addr_b = '0;

    // Reset state, with a client request pending
    repeat (2) @(posedge clk);
    #3;
    check_eq("rst_c0_ready", 32'(c0_ready), 0);
    check_eq("rst_rf_we", 32'(rf_we), 0);
    check_eq("rst_busy_done", 32'({swap_busy, swap_done}), 0);
    check_eq("rst_rvalid", 32'({c1_rvalid, c0_rvalid}), 0);
    check_eq("rst_rdata", 32'(rdata), 0);
    check_eq("rst_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    reset_n = 1'b1; c0_valid = 1'b0; c0_we = 1'b0;

    // Both clients hold valid for 4 cycles
`ifdef REG_FILE_SCHED_RR_EN
    exp_q.push_back(2'b01); exp_q.push_back(2'b10); exp_q.push_back(2'b01); exp_q.push_back(2'b10);
`else
    repeat (4) exp_q.push_back(2'b01);
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin c0_valid = 1'b1; c1_valid = 1'b1; end
      #1;
      check_eq("arb_grant", 32'({c1_ready, c0_ready}), 32'(exp_q.pop_front()));
    end
    @(negedge clk);
    c0_valid = 1'b0; c1_valid = 1'b0;

    // c0 write then c1 read of the same address
    client_wr(1'b0, 7'd5, 8'h3C);
    @(negedge clk);
    c1_valid = 1'b1; c1_we = 1'b0; c1_addr = 7'd5;
    #1;
    check_eq("rd_c1_ready", 32'({c1_ready, c0_ready}), 32'(2'b10));
    @(negedge clk);
    c1_valid = 1'b0;
    #1;
    check_eq("rd_c1_rvalid", 32'({c1_rvalid, c0_rvalid}), 32'(2'b10));
    check_eq("rd_rdata", 32'(rdata), 32'h3C);
    @(negedge clk);
    #1;
    check_eq("rd_rvalid_pulse", 32'(c1_rvalid), 0);

    // Basic swap 2 <-> 9
    client_wr(1'b0, 7'd2, 8'h11);
    client_wr(1'b1, 7'd9, 8'h22);
    run_swap(7'd2, 7'd9, -1, busy_n, done_n);
    check_eq("swap_busy_cycles", 32'(busy_n), 32'(SWAP_CYCLES));
    check_eq("swap_done_pulses", 32'(done_n), 1);
    check_eq("swap_mem2", 32'(mem[2]), 32'h22);
    check_eq("swap_mem9", 32'(mem[9]), 32'h11);

    // Swap and client request together: swap wins, client waits past done
    @(negedge clk);
    c0_valid = 1'b1; c0_we = 1'b1; c0_addr = 7'd20; c0_wdata = 8'h55;
    swap_start = 1'b1; swap_addr_a = 7'd3; swap_addr_b = 7'd4;
    #1;
    check_eq("prio_c0_ready", 32'(c0_ready), 0);
    done_at = -1; grant_at = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      swap_start = 1'b0;
      #1;
      if (swap_done && done_at < 0) done_at = i;
      if (c0_ready && grant_at < 0) grant_at = i;
    end
    c0_valid = 1'b0; c0_we = 1'b0;
    check_eq("prio_done_at", 32'(done_at), 5);
    check_eq("prio_grant_at", 32'(grant_at), 6);
    check_eq("prio_mem20", 32'(mem[20]), 32'h55);

    // A == B with a re-pulse of swap_start mid-swap
    client_wr(1'b0, 7'd7, 8'h77);
    run_swap(7'd7, 7'd7, 2, busy_n, done_n);
    check_eq("same_busy_cycles", 32'(busy_n), 32'(SWAP_CYCLES));
    check_eq("same_done_pulses", 32'(done_n), 1);
    check_eq("same_mem7", 32'(mem[7]), 32'h77);

    // Reset lands in SW_WR_B
    client_wr(1'b0, 7'd10, 8'hA1);
    client_wr(1'b0, 7'd11, 8'hB2);
    @(negedge clk);
    swap_start = 1'b1; swap_addr_a = 7'd10; swap_addr_b = 7'd11;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      swap_start = 1'b0;
    end
    #1;
    check_eq("rst_mid_state", 32'(state_dbg), 32'(SW_WR_B));
    check_eq("rst_mid_rf_we", 32'(rf_we), 1);
    check_eq("rst_mid_rdata_before", 32'(rdata), 32'h3C);
    reset_n = 1'b0;
    #1;
    check_eq("rst_mid_busy", 32'(swap_busy), 0);
    check_eq("rst_mid_rf_we_off", 32'(rf_we), 0);
    check_eq("rst_mid_rdata", 32'(rdata), 0);
    check_eq("rst_mid_state_idle", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    reset_n = 1'b1;
    done_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (swap_done) done_n++;
    end
    check_eq("rst_mid_no_done", 32'(done_n), 0);
    check_eq("rst_mid_memA", 32'(mem[10]), 32'hB2);
    check_eq("rst_mid_memB", 32'(mem[11]), 32'hB2);

    // Normal service resumes after reset
    @(negedge clk);
    c1_valid = 1'b1; c1_we = 1'b0; c1_addr = 7'd9;
    #1;
    check_eq("post_c1_ready", 32'(c1_ready), 1);
    @(negedge clk);
    c1_valid = 1'b0;
    #1;
    check_eq("post_rvalid", 32'(c1_rvalid), 1);
    check_eq("post_rdata", 32'(rdata), 32'h11);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
